keypad_encoder: RTL and testbench

KEYPAD_ENCODER -- requirements
Module: keypad_encoder

---
 rtl/keypad_pkg.sv | 25 ++
 rtl/keypad_encoder_sync2.sv | 27 ++
 rtl/keypad_encoder.sv | 139 +++++++++++++
 tb/tb_keypad_encoder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and widths for the keypad encoder.
// Holds the FSM encoding, key/BCD widths and the captured-key payload.
package keypad_pkg;

  localparam int unsigned KEY_COUNT = 10;
  localparam int unsigned BCD_W     = 4;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned DIG_W     = 2;

  typedef logic [KEY_COUNT-1:0] key_vec_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_STROBE   = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  // Key pattern latched in IDLE plus its BCD index.
  typedef struct packed {
    key_vec_t             pattern;
    logic [BCD_W-1:0]     index;
  } key_cap_t;

endpackage

// File: rtl/keypad_encoder_sync2.sv
// Two-flop synchronizer for asynchronous level inputs.
// Both stages clear on reset so no stale key survives a reset.
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clock,
  input  logic             clearn,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_encoder.sv
// Debounced 10-key keypad to BCD encoder driving a timer load interface.
// One strobe per qualified press; a key must be released before the next.
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned MAX_DIGITS      = 3
) (
  input  logic                 clock,
  input  logic                 clearn,
  input  logic [KEY_COUNT-1:0] keypad,
  input  logic                 enablen,
  input  logic                 restartn,
  output logic [BCD_W-1:0]     data,
  output logic                 loadn,
  output logic [DIG_W-1:0]     digits
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIG_W-1:0] DIG_MAX  = DIG_W'(MAX_DIGITS);

  key_vec_t          w_key;
  logic              w_onehot;
  logic [BCD_W-1:0]  w_index;

  state_t            r_state;
  key_cap_t          r_cap;
  logic [CNT_W-1:0]  r_cnt;
  logic [BCD_W-1:0]  r_data;
  logic              r_loadn;
  logic [DIG_W-1:0]  r_digits;

  state_t            w_state_nxt;
  key_cap_t          w_cap_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [BCD_W-1:0]  w_data_nxt;
  logic              w_loadn_nxt;
  logic [DIG_W-1:0]  w_digits_nxt;
  logic              w_strobe;

  sync2 #(
    .WIDTH (KEY_COUNT)
  ) u_sync2 (
    .clock  (clock),
    .clearn (clearn),
    .i_d    (keypad),
    .o_q    (w_key)
  );

  // A single pressed key: nonzero with no second bit set.
  assign w_onehot = (w_key != '0) && ((w_key & (w_key - key_vec_t'(1))) == '0);

  always_comb begin
    w_index = '0;
    for (int i = 0; i < int'(KEY_COUNT); i++) begin
      if (w_key[i]) w_index = BCD_W'(i);
    end
  end

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      r_state  <= ST_IDLE;
      r_cap    <= '0;
      r_cnt    <= '0;
      r_data   <= '0;
      r_loadn  <= 1'b1;
      r_digits <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cap    <= w_cap_nxt;
      r_cnt    <= w_cnt_nxt;
      r_data   <= w_data_nxt;
      r_loadn  <= w_loadn_nxt;
      r_digits <= w_digits_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cap_nxt    = r_cap;
    w_cnt_nxt    = r_cnt;
    w_data_nxt   = r_data;
    w_loadn_nxt  = 1'b1;
    w_digits_nxt = r_digits;
    w_strobe     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!enablen && w_onehot) begin
          w_cap_nxt.pattern = w_key;
          w_cap_nxt.index   = w_index;
          w_cnt_nxt         = '0;
          w_state_nxt       = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (enablen || (w_key != r_cap.pattern)) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_STROBE;
          w_strobe    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_STROBE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        // Any key activity restarts the release qualification.
        if (w_key != '0) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Saturated entries still walk through STROBE, just without a load.
    if (w_strobe && (r_digits < DIG_MAX)) begin
      w_data_nxt   = r_cap.index;
      w_loadn_nxt  = 1'b0;
      w_digits_nxt = r_digits + DIG_W'(1);
    end

    if (!restartn) w_digits_nxt = '0;
  end

  assign data   = r_data;
  assign loadn  = r_loadn;
  assign digits = r_digits;

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed self-checking bench for keypad_encoder at default parameters.
module tb_keypad_encoder;

  logic       clock = 1'b0;
  logic       clearn;
  logic [9:0] keypad;
  logic       enablen;
  logic       restartn;
  logic [3:0] data;
  logic       loadn;
  logic [1:0] digits;

  int checks   = 0;
  int failures = 0;
  int n_strobes = 0;

  keypad_encoder dut (
    .clock    (clock),
    .clearn   (clearn),
    .keypad   (keypad),
    .enablen  (enablen),
    .restartn (restartn),
    .data     (data),
    .loadn    (loadn),
    .digits   (digits)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (loadn === 1'b0) n_strobes = n_strobes + 1;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic press_release(input int key, input int hold);
    keypad = 10'(1 << key);
    repeat (hold) step();
    keypad = '0;
    repeat (12) step();
  endtask

  int s0;
  bit found;

  initial begin
    clearn   = 1'b0;
    keypad   = '0;
    enablen  = 1'b0;
    restartn = 1'b1;
    repeat (3) step();
    chk("rst_loadn", 32'(loadn), 1);
    chk("rst_data", 32'(data), 0);
    chk("rst_digits", 32'(digits), 0);

    // Key 7 held from just before edge 1: strobe after edge 7 only.
    clearn = 1'b1;
    keypad = 10'(1 << 7);
    for (int e = 1; e <= 6; e++) begin
      step();
      chk($sformatf("k7_pre_e%0d_loadn", e), 32'(loadn), 1);
    end
    step();
    chk("k7_e7_loadn", 32'(loadn), 0);
    chk("k7_e7_data", 32'(data), 7);
    chk("k7_e7_digits", 32'(digits), 1);
    step();
    chk("k7_e8_loadn", 32'(loadn), 1);
    repeat (4) step();
    keypad = '0;
    repeat (12) step();
    chk("k7_one_strobe", 32'(n_strobes), 1);
    chk("k7_digits_hold", 32'(digits), 1);

    // Restart, then keys 1..4: fourth press saturates.
    restartn = 1'b0;
    step();
    restartn = 1'b1;
    chk("restart_digits", 32'(digits), 0);
    s0 = n_strobes;
    press_release(1, 10);
    chk("seq_k1_data", 32'(data), 1);
    press_release(2, 10);
    chk("seq_k2_data", 32'(data), 2);
    press_release(3, 10);
    chk("seq_k3_data", 32'(data), 3);
    chk("seq_k3_digits", 32'(digits), 3);
    press_release(4, 10);
    chk("seq_k4_data", 32'(data), 3);
    chk("seq_k4_digits", 32'(digits), 3);
    chk("seq_strobes", 32'(n_strobes - s0), 3);

    // Short glitch on key 5.
    restartn = 1'b0;
    step();
    restartn = 1'b1;
    s0 = n_strobes;
    press_release(5, 2);
    chk("glitch_strobes", 32'(n_strobes - s0), 0);
    chk("glitch_data", 32'(data), 3);
    chk("glitch_digits", 32'(digits), 0);
    chk("glitch_loadn", 32'(loadn), 1);

    // Keys 2 and 6 together, then 6 released.
    s0 = n_strobes;
    keypad = 10'b0001000100;
    repeat (12) step();
    chk("multi_strobes", 32'(n_strobes - s0), 0);
    keypad = 10'b0000000100;
    repeat (10) step();
    chk("multi_then2_strobes", 32'(n_strobes - s0), 1);
    chk("multi_then2_data", 32'(data), 2);
    chk("multi_then2_digits", 32'(digits), 1);
    keypad = '0;
    repeat (12) step();

    // Key 9 held while disabled, then enabled.
    s0 = n_strobes;
    enablen = 1'b1;
    keypad = 10'(1 << 9);
    repeat (12) step();
    chk("dis_strobes", 32'(n_strobes - s0), 0);
    chk("dis_data", 32'(data), 2);
    enablen = 1'b0;
    repeat (10) step();
    chk("en_strobes", 32'(n_strobes - s0), 1);
    chk("en_data", 32'(data), 9);
    chk("en_digits", 32'(digits), 2);
    keypad = '0;
    repeat (12) step();

    // Restart coinciding with the strobe edge: strobe kept, count cleared.
    keypad = 10'(1 << 8);
    repeat (6) step();
    restartn = 1'b0;
    step();
    chk("rs_prio_loadn", 32'(loadn), 0);
    chk("rs_prio_data", 32'(data), 8);
    chk("rs_prio_digits", 32'(digits), 0);
    restartn = 1'b1;
    step();
    chk("rs_prio_after_loadn", 32'(loadn), 1);
    chk("rs_prio_after_digits", 32'(digits), 0);
    keypad = '0;
    repeat (12) step();

    // Reset pulsed in the strobe cycle, key still held.
    keypad = 10'(1 << 4);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (loadn === 1'b0) found = 1'b1;
    end
    chk("rst_mid_strobe_seen", 32'(found), 1);
    chk("rst_mid_pre_digits", 32'(digits), 1);
    clearn = 1'b0;
    #1;
    chk("rst_mid_loadn", 32'(loadn), 1);
    chk("rst_mid_digits", 32'(digits), 0);
    chk("rst_mid_data", 32'(data), 0);
    step();
    clearn = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      chk($sformatf("requal_e%0d_loadn", e), 32'(loadn), 1);
    end
    step();
    chk("requal_e7_loadn", 32'(loadn), 0);
    chk("requal_e7_data", 32'(data), 4);
    chk("requal_e7_digits", 32'(digits), 1);
    keypad = '0;
    repeat (12) step();
    chk("end_loadn", 32'(loadn), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
